// File: rtl/nvme_sq_pkg.sv
// Shared types and helpers for the NVMe submission-queue scheduler: FSM states,
// queue ids, and per-queue depth/base-address derivation.
package nvme_sq_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WRITE    = 2'd1,
        DOORBELL = 2'd2
    } sq_state_e;

    localparam int NUM_Q     = 4;
    localparam int WORD_BITS = 128;
    localparam int CMD_BITS  = 512;
    localparam int BEATS     = CMD_BITS / WORD_BITS;

    localparam logic [1:0] QID_ADM0 = 2'd0;
    localparam logic [1:0] QID_IO0  = 2'd1;
    localparam logic [1:0] QID_ADM1 = 2'd2;
    localparam logic [1:0] QID_IO1  = 2'd3;

    localparam logic [NUM_Q-1:0] ADMIN_MASK = 4'b0101;

    function automatic int sq_depth(input logic [1:0] qid, input int adm, input int io);
        return qid[0] ? io : adm;
    endfunction

    // Slot layout must match the SQ window decode in the PCIe slave.
    function automatic int sq_base(input logic [1:0] qid, input int adm, input int io);
        case (qid)
            QID_ADM0: return 0;
            QID_IO0:  return adm * 4;
            QID_ADM1: return (io + adm) * 4;
            default:  return (io + 2 * adm) * 4;
        endcase
    endfunction

    function automatic logic [7:0] wrap_inc(input logic [7:0] x, input logic [7:0] last);
        return (x == last) ? 8'd0 : x + 8'd1;
    endfunction

endpackage

// File: rtl/nvme_rr_arbiter.sv
// Four-way round-robin picker over an eligibility mask, starting after i_last.
// With NVME_SQ_ADMIN_PRIO_EN defined, eligible admin queues mask out IO queues.
module nvme_rr_arbiter
    import nvme_sq_pkg::*;
(
    input  logic [NUM_Q-1:0] i_elig,
    input  logic [1:0]       i_last,
    output logic             o_valid,
    output logic [1:0]       o_grant
);

    logic [NUM_Q-1:0] w_mask;

`ifdef NVME_SQ_ADMIN_PRIO_EN
    always_comb begin
        w_mask = i_elig;
        if ((i_elig & ADMIN_MASK) != '0)
            w_mask = i_elig & ADMIN_MASK;
    end
`else
    assign w_mask = i_elig;
`endif

    // Scanning from farthest to nearest lets the nearest eligible queue win.
    always_comb begin
        o_valid = |w_mask;
        o_grant = i_last;
        for (int k = NUM_Q; k >= 1; k--) begin
            if (w_mask[2'(i_last + 2'(k))])
                o_grant = 2'(i_last + 2'(k));
        end
    end

endmodule

// File: rtl/nvme_sq_arbiter.sv
// Submission-queue scheduler: arbitrates four command sources, writes each command
// into its Tx buffer slot, rings the tail doorbell. Option macro: NVME_SQ_ADMIN_PRIO_EN.
`ifndef ADM_SQ_NUM
`define ADM_SQ_NUM 32
`endif
`ifndef IO_SQ_NUM
`define IO_SQ_NUM 64
`endif

module nvme_sq_arbiter
    import nvme_sq_pkg::*;
#(
    parameter int TX_ADDR_BITS = 12,
    parameter int ADM_SQ_DEPTH = `ADM_SQ_NUM,
    parameter int IO_SQ_DEPTH  = `IO_SQ_NUM
) (
    input  logic                    axi_aclk,
    input  logic                    axi_aresetn,
    input  logic [3:0]              req_valid,
    input  logic [2047:0]           req_cmd,
    output logic [3:0]              req_ready,
    output logic                    tx_write,
    output logic [TX_ADDR_BITS-1:0] tx_waddr,
    output logic [127:0]            tx_wdata,
    input  logic                    cq_head_valid,
    input  logic [1:0]              cq_head_qid,
    input  logic [7:0]              cq_head_ptr,
    output logic                    db_valid,
    input  logic                    db_ready,
    output logic [1:0]              db_qid,
    output logic [7:0]              db_tail,
    output logic [3:0]              sq_full,
    output logic                    busy
);

    localparam logic [NUM_Q-1:0][7:0] DEPTH_M1 = {
        8'(sq_depth(QID_IO1,  ADM_SQ_DEPTH, IO_SQ_DEPTH) - 1),
        8'(sq_depth(QID_ADM1, ADM_SQ_DEPTH, IO_SQ_DEPTH) - 1),
        8'(sq_depth(QID_IO0,  ADM_SQ_DEPTH, IO_SQ_DEPTH) - 1),
        8'(sq_depth(QID_ADM0, ADM_SQ_DEPTH, IO_SQ_DEPTH) - 1)
    };

    localparam logic [NUM_Q-1:0][TX_ADDR_BITS-1:0] SQ_BASE = {
        TX_ADDR_BITS'(sq_base(QID_IO1,  ADM_SQ_DEPTH, IO_SQ_DEPTH)),
        TX_ADDR_BITS'(sq_base(QID_ADM1, ADM_SQ_DEPTH, IO_SQ_DEPTH)),
        TX_ADDR_BITS'(sq_base(QID_IO0,  ADM_SQ_DEPTH, IO_SQ_DEPTH)),
        TX_ADDR_BITS'(sq_base(QID_ADM0, ADM_SQ_DEPTH, IO_SQ_DEPTH))
    };

    sq_state_e                r_state, w_state_nxt;
    logic [1:0]               r_beat, w_beat_nxt;
    logic [1:0]               r_gq, w_gq_nxt;
    logic [1:0]               r_last_grant;
    logic                     w_commit;
    logic [NUM_Q-1:0][7:0]    r_tail, w_tail_nxt;
    logic [NUM_Q-1:0][7:0]    r_head, w_head_nxt;
    logic [NUM_Q-1:0]         r_sq_full, w_full_nxt;

    logic                     w_arb_valid;
    logic [1:0]               w_arb_grant;
    logic [15:0][127:0]       w_cmd_words;

    logic                     r_tx_write, w_tx_write_nxt;
    logic [TX_ADDR_BITS-1:0]  r_tx_waddr, w_tx_waddr_nxt;
    logic [127:0]             r_tx_wdata, w_tx_wdata_nxt;
    logic [3:0]               r_req_ready, w_req_ready_nxt;
    logic                     r_db_valid, w_db_valid_nxt;
    logic [1:0]               r_db_qid, w_db_qid_nxt;
    logic [7:0]               r_db_tail, w_db_tail_nxt;
    logic                     r_busy, w_busy_nxt;

    assign w_cmd_words = req_cmd;

    // A same-cycle head update is not visible here: eligibility uses registered full flags.
    nvme_rr_arbiter u_rr_arbiter (
        .i_elig  (req_valid & ~r_sq_full),
        .i_last  (r_last_grant),
        .o_valid (w_arb_valid),
        .o_grant (w_arb_grant)
    );

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_gq_nxt    = r_gq;
        w_commit    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_arb_valid) begin
                    w_state_nxt = WRITE;
                    w_beat_nxt  = 2'd0;
                    w_gq_nxt    = w_arb_grant;
                end
            end
            WRITE: begin
                if (r_beat == 2'(BEATS - 1)) begin
                    w_state_nxt = DOORBELL;
                    w_commit    = 1'b1;
                end else begin
                    w_beat_nxt = r_beat + 2'd1;
                end
            end
            DOORBELL: begin
                if (db_ready)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_tail_nxt = r_tail;
        w_head_nxt = r_head;
        if (w_commit)
            w_tail_nxt[r_gq] = wrap_inc(r_tail[r_gq], DEPTH_M1[r_gq]);
        if (cq_head_valid)
            w_head_nxt[cq_head_qid] = cq_head_ptr;
        for (int q = 0; q < NUM_Q; q++)
            w_full_nxt[q] = (wrap_inc(r_tail[q], DEPTH_M1[q]) == r_head[q]);
    end

    // Outputs are computed from the next state so they are registered yet still line up with it.
    always_comb begin
        w_tx_write_nxt  = 1'b0;
        w_tx_waddr_nxt  = '0;
        w_tx_wdata_nxt  = '0;
        w_req_ready_nxt = '0;
        w_db_valid_nxt  = 1'b0;
        w_db_qid_nxt    = '0;
        w_db_tail_nxt   = '0;
        w_busy_nxt      = (w_state_nxt != IDLE);
        if (w_state_nxt == WRITE) begin
            w_tx_write_nxt = 1'b1;
            w_tx_waddr_nxt = SQ_BASE[w_gq_nxt]
                           + TX_ADDR_BITS'({r_tail[w_gq_nxt], 2'b00})
                           + TX_ADDR_BITS'(w_beat_nxt);
            w_tx_wdata_nxt = w_cmd_words[{w_gq_nxt, w_beat_nxt}];
            if (w_beat_nxt == 2'(BEATS - 1))
                w_req_ready_nxt = 4'b0001 << w_gq_nxt;
        end
        if (w_state_nxt == DOORBELL) begin
            w_db_valid_nxt = 1'b1;
            w_db_qid_nxt   = w_gq_nxt;
            w_db_tail_nxt  = w_tail_nxt[w_gq_nxt];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_state      <= IDLE;
            r_beat       <= '0;
            r_gq         <= '0;
            r_last_grant <= 2'd3;
            r_tail       <= '0;
            r_head       <= '0;
            r_sq_full    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_beat    <= w_beat_nxt;
            r_gq      <= w_gq_nxt;
            r_tail    <= w_tail_nxt;
            r_head    <= w_head_nxt;
            r_sq_full <= w_full_nxt;
            if (w_commit)
                r_last_grant <= r_gq;
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_tx_write  <= 1'b0;
            r_tx_waddr  <= '0;
            r_tx_wdata  <= '0;
            r_req_ready <= '0;
            r_db_valid  <= 1'b0;
            r_db_qid    <= '0;
            r_db_tail   <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_tx_write  <= w_tx_write_nxt;
            r_tx_waddr  <= w_tx_waddr_nxt;
            r_tx_wdata  <= w_tx_wdata_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_db_valid  <= w_db_valid_nxt;
            r_db_qid    <= w_db_qid_nxt;
            r_db_tail   <= w_db_tail_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign tx_write  = r_tx_write;
    assign tx_waddr  = r_tx_waddr;
    assign tx_wdata  = r_tx_wdata;
    assign req_ready = r_req_ready;
    assign db_valid  = r_db_valid;
    assign db_qid    = r_db_qid;
    assign db_tail   = r_db_tail;
    assign sq_full   = r_sq_full;
    assign busy      = r_busy;

endmodule

// File: tb/tb_nvme_sq_arbiter.sv
// Directed bench for nvme_sq_arbiter with ADM depth 4 and IO depth 8
// (slot bases 0/16/48/64); expectations track NVME_SQ_ADMIN_PRIO_EN.
module tb_nvme_sq_arbiter;

    logic          axi_aclk = 1'b0;
    logic          axi_aresetn;
    logic [3:0]    req_valid;
    logic [2047:0] req_cmd;
    logic [3:0]    req_ready;
    logic          tx_write;
    logic [11:0]   tx_waddr;
    logic [127:0]  tx_wdata;
    logic          cq_head_valid;
    logic [1:0]    cq_head_qid;
    logic [7:0]    cq_head_ptr;
    logic          db_valid;
    logic          db_ready;
    logic [1:0]    db_qid;
    logic [7:0]    db_tail;
    logic [3:0]    sq_full;
    logic          busy;

    int checks = 0;
    int errors = 0;

    always #5 axi_aclk = ~axi_aclk;

    nvme_sq_arbiter #(
        .TX_ADDR_BITS (12),
        .ADM_SQ_DEPTH (4),
        .IO_SQ_DEPTH  (8)
    ) dut (
        .axi_aclk      (axi_aclk),
        .axi_aresetn   (axi_aresetn),
        .req_valid     (req_valid),
        .req_cmd       (req_cmd),
        .req_ready     (req_ready),
        .tx_write      (tx_write),
        .tx_waddr      (tx_waddr),
        .tx_wdata      (tx_wdata),
        .cq_head_valid (cq_head_valid),
        .cq_head_qid   (cq_head_qid),
        .cq_head_ptr   (cq_head_ptr),
        .db_valid      (db_valid),
        .db_ready      (db_ready),
        .db_qid        (db_qid),
        .db_tail       (db_tail),
        .sq_full       (sq_full),
        .busy          (busy)
    );

    function automatic logic [127:0] cmd_word(input int q, input int b);
        return {32'hC0DE_0000 + 32'(q * 16 + b), 32'(q), 32'(b), 32'hA5A5_0000 + 32'(q)};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tx_write"},  tx_write,  0);
        check({tag, "_tx_waddr"},  tx_waddr,  0);
        check({tag, "_tx_wdata"},  tx_wdata,  0);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_db_valid"},  db_valid,  0);
        check({tag, "_db_qid"},    db_qid,    0);
        check({tag, "_db_tail"},   db_tail,   0);
        check({tag, "_sq_full"},   sq_full,   0);
        check({tag, "_busy"},      busy,      0);
    endtask

    task automatic do_reset();
        axi_aresetn   = 1'b0;
        req_valid     = '0;
        cq_head_valid = 1'b0;
        db_ready      = 1'b1;
        repeat (2) @(negedge axi_aclk);
        axi_aresetn = 1'b1;
        @(negedge axi_aclk);
    endtask

    task automatic wait_write(input string tag);
        int n = 0;
        while (tx_write !== 1'b1 && n < 40) begin
            @(negedge axi_aclk);
            n++;
        end
        check({tag, "_grant_seen"}, tx_write, 1);
    endtask

    // Waits for the first beat, checks the four beats, returns at the first doorbell cycle.
    task automatic do_cmd(input string tag, input logic [1:0] q, input logic [11:0] addr0,
                          input logic [7:0] tail_exp);
        wait_write(tag);
        if (tx_write === 1'b1) begin
            for (int b = 0; b < 4; b++) begin
                check($sformatf("%s_write%0d", tag, b), tx_write, 1);
                check($sformatf("%s_addr%0d", tag, b), tx_waddr, addr0 + 12'(b));
                check($sformatf("%s_data%0d", tag, b), tx_wdata, cmd_word(int'(q), b));
                check($sformatf("%s_ready%0d", tag, b), req_ready,
                      (b == 3) ? (4'b0001 << q) : 4'b0000);
                @(negedge axi_aclk);
            end
            check({tag, "_db_valid"}, db_valid, 1);
            check({tag, "_db_qid"},   db_qid,   q);
            check({tag, "_db_tail"},  db_tail,  tail_exp);
            check({tag, "_db_nowr"},  tx_write, 0);
        end
    endtask

    initial begin
        axi_aresetn   = 1'b0;
        req_valid     = '0;
        cq_head_valid = 1'b0;
        cq_head_qid   = '0;
        cq_head_ptr   = '0;
        db_ready      = 1'b1;
        req_cmd       = '0;
        for (int q = 0; q < 4; q++)
            for (int b = 0; b < 4; b++)
                req_cmd[q * 512 + b * 128 +: 128] = cmd_word(q, b);

        @(negedge axi_aclk);
        check_all_zero("rst");
        axi_aresetn = 1'b1;
        @(negedge axi_aclk);

        // Single IO SSD0 command, doorbell stalled for 10 cycles
        req_valid = 4'b0010;
        db_ready  = 1'b0;
        do_cmd("io0", 2'd1, 12'd16, 8'd1);
        req_valid = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge axi_aclk);
            check($sformatf("stall%0d_db_valid", i), db_valid, 1);
            check($sformatf("stall%0d_db_qid", i), db_qid, 1);
            check($sformatf("stall%0d_db_tail", i), db_tail, 1);
            check($sformatf("stall%0d_tx_write", i), tx_write, 0);
            check($sformatf("stall%0d_req_ready", i), req_ready, 0);
            check($sformatf("stall%0d_busy", i), busy, 1);
        end
        db_ready = 1'b1;
        @(negedge axi_aclk);
        check("stall_release_db_valid", db_valid, 0);
        check("stall_release_busy", busy, 0);

        // Round-robin over all four requesters
        do_reset();
        req_valid = 4'hF;
        do_cmd("rr0", 2'd0, 12'd0,  8'd1);
        do_cmd("rr1", 2'd1, 12'd16, 8'd1);
        do_cmd("rr2", 2'd2, 12'd48, 8'd1);
        do_cmd("rr3", 2'd3, 12'd64, 8'd1);
        do_cmd("rr4", 2'd0, 12'd4,  8'd2);
        req_valid = '0;
        @(negedge axi_aclk);
        check("rr_idle_busy", busy, 0);

        // Fill admin SQ0, then free one slot via a head update; last slot wraps
        do_reset();
        req_valid = 4'b0001;
        do_cmd("fill0", 2'd0, 12'd0, 8'd1);
        do_cmd("fill1", 2'd0, 12'd4, 8'd2);
        do_cmd("fill2", 2'd0, 12'd8, 8'd3);
        for (int i = 0; i < 8; i++) begin
            @(negedge axi_aclk);
            check($sformatf("full%0d_sq_full", i), sq_full, 4'b0001);
            check($sformatf("full%0d_tx_write", i), tx_write, 0);
            check($sformatf("full%0d_busy", i), busy, 0);
        end
        cq_head_valid = 1'b1;
        cq_head_qid   = 2'd0;
        cq_head_ptr   = 8'd1;
        @(negedge axi_aclk);
        cq_head_valid = 1'b0;
        check("head_upd_still_full", sq_full, 4'b0001);
        @(negedge axi_aclk);
        check("head_upd_cleared", sq_full, 4'b0000);
        check("head_upd_no_write_yet", tx_write, 0);
        do_cmd("wrap", 2'd0, 12'd12, 8'd0);
        check("wrap_db_sq_full", sq_full, 4'b0000);
        req_valid = '0;
        @(negedge axi_aclk);
        check("wrap_after_full", sq_full, 4'b0001);
        check("wrap_after_busy", busy, 0);

        // Admin vs IO ordering from reset
        do_reset();
        req_valid = 4'b0110;
`ifdef NVME_SQ_ADMIN_PRIO_EN
        do_cmd("prio_a", 2'd2, 12'd48, 8'd1);
        do_cmd("prio_b", 2'd1, 12'd16, 8'd1);
`else
        do_cmd("prio_a", 2'd1, 12'd16, 8'd1);
        do_cmd("prio_b", 2'd2, 12'd48, 8'd1);
`endif
        req_valid = '0;
        @(negedge axi_aclk);

        // Reset during beat 2 of the second command abandons it and clears tails
        do_reset();
        req_valid = 4'b0001;
        do_cmd("rst_a", 2'd0, 12'd0, 8'd1);
        wait_write("rst_b");
        check("rst_b_beat0_addr", tx_waddr, 12'd4);
        @(negedge axi_aclk);
        @(negedge axi_aclk);
        check("rst_b_beat2_addr", tx_waddr, 12'd6);
        axi_aresetn = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(negedge axi_aclk);
        check_all_zero("rst_hold");
        axi_aresetn = 1'b1;
        do_cmd("rst_c", 2'd0, 12'd0, 8'd1);
        req_valid = '0;
        repeat (2) @(negedge axi_aclk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
